// File: rtl/warp_scheduler_if.sv
// Shared types and the scheduler's datapath-facing bundle.
// master = scheduler side, slave = fetch/decode/LSU side.
package warp_scheduler_pkg;
   localparam int PC_W = 16;
   typedef logic [PC_W-1:0] instruction_memory_address_t;
   typedef enum logic [2:0] {
      WARP_IDLE,
      WARP_FETCH,
      WARP_DECODE,
      WARP_REQUEST,
      WARP_WAIT,
      WARP_EXECUTE,
      WARP_UPDATE,
      WARP_DONE
   } warp_state_t;
endpackage

interface warp_scheduler_if
   import warp_scheduler_pkg::*;
   #(parameter int NUM_WARPS = 4);
   localparam int WARP_ID_W =
      NUM_WARPS > 1 ? $clog2(NUM_WARPS) : 1;

   logic                        start;
   instruction_memory_address_t start_pc;
   logic [NUM_WARPS-1:0]        warp_valid_mask;
   logic                        fetch_ready;
   logic                        decoded_mem_rw;
   logic                        decoded_halt;
   logic                        lsu_done;
   instruction_memory_address_t next_pc;
   logic [NUM_WARPS-1:0]        warp_enable;
   warp_state_t                 warp_state;
   logic [WARP_ID_W-1:0]        current_warp;
   instruction_memory_address_t pc_out;
   logic                        fetch_req;
   logic                        lsu_req;
   logic                        kernel_done;

   modport master (
      input  start, start_pc, warp_valid_mask,
      input  fetch_ready, decoded_mem_rw,
      input  decoded_halt, lsu_done, next_pc,
      output warp_enable, warp_state,
      output current_warp, pc_out,
      output fetch_req, lsu_req, kernel_done
   );

   modport slave (
      output start, start_pc, warp_valid_mask,
      output fetch_ready, decoded_mem_rw,
      output decoded_halt, lsu_done, next_pc,
      input  warp_enable, warp_state,
      input  current_warp, pc_out,
      input  fetch_req, lsu_req, kernel_done
   );
endinterface

// File: rtl/warp_scheduler.sv
// Round-robin warp scheduler: one instruction in flight,
// per-warp PC and halt tracking, kernel_done on all halted.
module warp_scheduler
   import warp_scheduler_pkg::*;
   #(parameter int NUM_WARPS = 4,
     localparam int WARP_ID_W =
        NUM_WARPS > 1 ? $clog2(NUM_WARPS) : 1)
   (input logic clk,
    input logic reset,
    warp_scheduler_if.master bus);

   typedef enum logic [1:0] {
      SCHED_IDLE,
      SCHED_SELECT,
      SCHED_RUN,
      SCHED_DONE
   } sched_t;

   sched_t                      sched_q, sched_d;
   warp_state_t                 ws_q, ws_d;
   logic [WARP_ID_W-1:0]        cur_q, rr_q;
   logic [NUM_WARPS-1:0]        mask_q;
   instruction_memory_address_t pc_q [NUM_WARPS];

   logic                        found;
   logic [WARP_ID_W-1:0]        pick, cand;
   logic                        run;

   // First active warp strictly after the rr pointer.
   always_comb begin
      found = 1'b0;
      pick  = rr_q;
      cand  = rr_q;
      for (int i = 1; i <= NUM_WARPS; i++) begin
         cand = WARP_ID_W'((int'(rr_q) + i) % NUM_WARPS);
         if (!found && mask_q[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sched_q <= SCHED_IDLE;
         ws_q    <= WARP_IDLE;
      end else begin
         sched_q <= sched_d;
         ws_q    <= ws_d;
      end
   end

   always_comb begin
      sched_d = sched_q;
      ws_d    = ws_q;
      unique case (sched_q)
         SCHED_IDLE:
            if (bus.start) sched_d = SCHED_SELECT;
         SCHED_SELECT:
            if (found) begin
               sched_d = SCHED_RUN;
               ws_d    = WARP_FETCH;
            end else begin
               sched_d = SCHED_DONE;
               ws_d    = WARP_DONE;
            end
         SCHED_RUN:
            unique case (ws_q)
               WARP_FETCH:
                  if (bus.fetch_ready) ws_d = WARP_DECODE;
               WARP_DECODE:
                  ws_d = WARP_REQUEST;
               WARP_REQUEST:
                  ws_d = bus.decoded_mem_rw ?
                         WARP_WAIT : WARP_EXECUTE;
               WARP_WAIT:
                  if (bus.lsu_done) ws_d = WARP_EXECUTE;
               WARP_EXECUTE:
                  ws_d = WARP_UPDATE;
               WARP_UPDATE: begin
                  sched_d = SCHED_SELECT;
                  ws_d    = bus.decoded_halt ?
                            WARP_DONE : WARP_IDLE;
               end
               default:
                  ws_d = WARP_IDLE;
            endcase
         SCHED_DONE:
            if (!bus.start) begin
               sched_d = SCHED_IDLE;
               ws_d    = WARP_IDLE;
            end
         default:
            sched_d = SCHED_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mask_q <= '0;
         cur_q  <= '0;
         rr_q   <= WARP_ID_W'(NUM_WARPS - 1);
         for (int i = 0; i < NUM_WARPS; i++)
            pc_q[i] <= '0;
      end else begin
         if (sched_q == SCHED_IDLE && bus.start) begin
            mask_q <= bus.warp_valid_mask;
            for (int i = 0; i < NUM_WARPS; i++)
               pc_q[i] <= bus.start_pc;
         end
         if (sched_q == SCHED_SELECT && found) begin
            cur_q <= pick;
            rr_q  <= pick;
         end
         if (sched_q == SCHED_RUN && ws_q == WARP_UPDATE) begin
            pc_q[cur_q] <= bus.next_pc;
            if (bus.decoded_halt) mask_q[cur_q] <= 1'b0;
         end
      end
   end

   // Outputs decode registered state only, so reset clears them at once.
   always_comb begin
      run              = (sched_q == SCHED_RUN);
      bus.warp_enable  = run ? (NUM_WARPS'(1) << cur_q) : '0;
      bus.warp_state   = ws_q;
      bus.current_warp = cur_q;
      bus.pc_out       = pc_q[cur_q];
      bus.fetch_req    = run && (ws_q == WARP_FETCH);
      bus.lsu_req      = run && (ws_q == WARP_WAIT);
      bus.kernel_done  = (sched_q == SCHED_DONE);
   end
endmodule

// File: tb/tb_warp_scheduler.sv
// Randomized bench for warp_scheduler with a per-instruction
// timeline model and directed literal checks.
module tb_warp_scheduler;
   import warp_scheduler_pkg::*;
   localparam int N = 4;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   warp_scheduler_if #(.NUM_WARPS(N)) bus();
   warp_scheduler #(.NUM_WARPS(N)) dut (
      .clk(clk), .reset(reset), .bus(bus));

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   int lreq_cnt = 0;

   bit          e_chk = 1'b0;
   logic [3:0]  e_en;
   warp_state_t e_ws;
   int          e_cur;
   logic [15:0] e_pc;
   bit          e_freq, e_lreq, e_kd;

   int mpc [N];
   bit mact [N];
   int mrr, mlast;
   bit mph;
   int ninstr;
   int issue_q [$];
   int exp_ord [8] = '{0, 1, 2, 3, 0, 1, 3, 0};

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d t=%0t",
                  name, act, exp, $time);
      end
   endtask

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (bus.lsu_req === 1'b1) lreq_cnt++;
      if (e_chk) begin
         chk("warp_enable", 32'(bus.warp_enable), 32'(e_en));
         chk("warp_state", 32'(bus.warp_state), 32'(e_ws));
         chk("current_warp", 32'(bus.current_warp), 32'(e_cur));
         chk("pc_out", 32'(bus.pc_out), 32'(e_pc));
         chk("fetch_req", 32'(bus.fetch_req), 32'(e_freq));
         chk("lsu_req", 32'(bus.lsu_req), 32'(e_lreq));
         chk("kernel_done", 32'(bus.kernel_done), 32'(e_kd));
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic edge_();
      @(posedge clk);
      #1;
   endtask

   task automatic set_exp(input logic [3:0] en,
                          input warp_state_t ws,
                          input int cur, input bit fr,
                          input bit lr, input bit kd);
      e_en = en; e_ws = ws; e_cur = cur;
      e_pc = 16'(mpc[cur]);
      e_freq = fr; e_lreq = lr; e_kd = kd;
      e_chk = 1'b1;
   endtask

   task automatic rand_ignored();
      bus.start           = 1'($urandom_range(0, 1));
      bus.start_pc        = 16'($urandom_range(0, 65535));
      bus.warp_valid_mask = 4'($urandom_range(0, 15));
      bus.fetch_ready     = 1'($urandom_range(0, 1));
      bus.lsu_done        = 1'($urandom_range(0, 1));
      bus.decoded_mem_rw  = 1'($urandom_range(0, 1));
      bus.decoded_halt    = 1'($urandom_range(0, 1));
      bus.next_pc         = 16'($urandom_range(0, 65535));
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         mpc[i] = 0;
         mact[i] = 1'b0;
      end
      mrr = N - 1; mlast = 0; mph = 1'b0;
   endtask

   task automatic do_reset();
      e_chk = 1'b0;
      reset = 1'b0;
      #1;
      chk("rst_enable", 32'(bus.warp_enable), 0);
      chk("rst_state", 32'(bus.warp_state), 32'(WARP_IDLE));
      chk("rst_cur", 32'(bus.current_warp), 0);
      chk("rst_pc", 32'(bus.pc_out), 0);
      chk("rst_fetch_req", 32'(bus.fetch_req), 0);
      chk("rst_lsu_req", 32'(bus.lsu_req), 0);
      chk("rst_kernel_done", 32'(bus.kernel_done), 0);
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   task automatic run_kernel(input logic [3:0] mask,
                             input int spc, input int mode,
                             input int abort_at,
                             output bit aborted);
      int w, f, l, npc, lsnap, last_sel, h;
      bit mem, halt;
      bit seen [N];
      logic [3:0] en;
      aborted = 1'b0;
      ninstr = 0;
      last_sel = 0;
      issue_q.delete();
      for (int i = 0; i < N; i++) seen[i] = 1'b0;
      rand_ignored();
      bus.start = 1'b1;
      bus.warp_valid_mask = mask;
      bus.start_pc = 16'(spc);
      set_exp(4'b0, WARP_IDLE, mlast, 0, 0, 0);
      edge_();
      for (int i = 0; i < N; i++) begin
         mpc[i] = spc;
         mact[i] = mask[i];
      end
      forever begin
         rand_ignored();
         set_exp(4'b0, mph ? WARP_DONE : WARP_IDLE,
                 mlast, 0, 0, 0);
         if (mode == 1) begin
            chk("t2_pc", 32'(bus.pc_out), 32'(spc + ninstr));
            if (ninstr > 0)
               chk("t2_period", 32'(cyc - last_sel), 6);
            last_sel = cyc;
         end
         w = -1;
         for (int i = 1; i <= N; i++)
            if (w < 0 && mact[(mrr + i) % N]) w = (mrr + i) % N;
         edge_();
         if (w < 0) break;
         mrr = w; mlast = w;
         issue_q.push_back(w);
         en = 4'(1 << w);
         case (mode)
            1: begin
               f = 0; mem = 0; l = 0;
               npc = (mpc[w] + 1) & 16'hffff;
               halt = (ninstr >= 2);
            end
            2: begin
               f = $urandom_range(0, 2); mem = 1; l = 3;
               npc = $urandom_range(0, 65535);
               halt = (ninstr >= 1);
            end
            3: begin
               f = $urandom_range(0, 2);
               mem = 1'($urandom_range(0, 1));
               l = $urandom_range(0, 2);
               npc = $urandom_range(0, 65535);
               halt = (w == 2) || (ninstr >= 8);
            end
            default: begin
               f = $urandom_range(0, 3);
               mem = 1'($urandom_range(0, 1));
               l = $urandom_range(0, 4);
               npc = $urandom_range(0, 65535);
               halt = ($urandom_range(0, 3) == 0) ||
                      (ninstr >= 30);
            end
         endcase
         lsnap = lreq_cnt;
         for (int i = 0; i <= f; i++) begin
            rand_ignored();
            bus.fetch_ready = (i == f);
            set_exp(en, WARP_FETCH, w, 1, 0, 0);
            if (i == 0 && !seen[w]) begin
               chk("first_pc", 32'(bus.pc_out), 32'(spc));
               seen[w] = 1'b1;
            end
            if (i == 0 && ninstr == abort_at) begin
               aborted = 1'b1;
               return;
            end
            edge_();
         end
         rand_ignored();
         set_exp(en, WARP_DECODE, w, 0, 0, 0);
         edge_();
         rand_ignored();
         bus.decoded_mem_rw = mem;
         set_exp(en, WARP_REQUEST, w, 0, 0, 0);
         edge_();
         if (mem) begin
            for (int i = 0; i <= l; i++) begin
               rand_ignored();
               bus.lsu_done = (i == l);
               set_exp(en, WARP_WAIT, w, 0, 1, 0);
               edge_();
            end
         end
         rand_ignored();
         set_exp(en, WARP_EXECUTE, w, 0, 0, 0);
         if (mode == 2)
            chk("t3_exec", 32'(bus.warp_state),
                32'(WARP_EXECUTE));
         edge_();
         rand_ignored();
         bus.decoded_halt = halt;
         bus.next_pc = 16'(npc);
         set_exp(en, WARP_UPDATE, w, 0, 0, 0);
         edge_();
         if (mode == 2)
            chk("t3_lsu_req_cycles", 32'(lreq_cnt - lsnap), 4);
         mpc[w] = npc;
         if (halt) mact[w] = 1'b0;
         mph = halt;
         ninstr++;
      end
      h = $urandom_range(0, 2);
      for (int i = 0; i <= h; i++) begin
         rand_ignored();
         bus.start = (i < h);
         set_exp(4'b0, WARP_DONE, mlast, 0, 0, 1);
         if (i == 0)
            chk("done_flag", 32'(bus.kernel_done), 1);
         edge_();
      end
      mph = 1'b0;
   endtask

   initial begin
      bit ab;
      int c2;
      rand_ignored();
      bus.start = 1'b0;
      model_reset();
      #2;
      do_reset();

      run_kernel(4'b0001, 0, 1, -1, ab);
      run_kernel(4'b0001, 16'h40, 2, -1, ab);

      do_reset();
      run_kernel(4'b1111, 16'h100, 3, -1, ab);
      chk("t4_len", 32'(issue_q.size() >= 8), 1);
      for (int i = 0; i < 8 && i < issue_q.size(); i++)
         chk("t4_order", 32'(issue_q[i]), 32'(exp_ord[i]));
      c2 = 0;
      foreach (issue_q[i]) if (issue_q[i] == 2) c2++;
      chk("t4_w2_once", 32'(c2), 1);

      run_kernel(4'b0000, 16'h22, 0, -1, ab);
      run_kernel(4'b1111, 0, 0, -1, ab);
      run_kernel(4'b1111, 8, 0, -1, ab);

      run_kernel(4'b1011, $urandom_range(0, 65535), 0, 2, ab);
      do_reset();

      for (int k = 0; k < 6; k++)
         run_kernel(4'($urandom_range(0, 15)),
                    $urandom_range(0, 65535), 0, -1, ab);

      e_chk = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
